gpr_rd_arb: RTL and testbench
=============================

GPR_RD_ARB -- requirements
Module: gpr_rd_arb

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4 (range 1..7); number of consecutive blocked cycles a debug read may wait before the block forces a pipeline stall.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 id_re1  input  1  ID read enable, GPR port 1.
REQ-005 id_raddr1  input  5  ID read address, GPR port 1.
REQ-006 id_re2  input  1  ID read enable, GPR port 2.
REQ-007 id_raddr2  input  5  ID read address, GPR port 2.
REQ-008 id_rdata1  output  32  read data returned to ID, port 1.
REQ-009 id_rdata2  output  32  read data returned to ID, port 2.
REQ-010 dbg_req  input  1  debug read request, level; held until dbg_ack.
REQ-011 dbg_addr  input  5  debug GPR address; stable while dbg_req is high.
REQ-012 dbg_ack  output  1  one-cycle pulse; dbg_data is valid in the same cycle.
REQ-013 dbg_data  output  32  registered debug read result.
REQ-014 rf_re1, rf_re2  output  1 each  regfile read enables.
REQ-015 rf_raddr1, rf_raddr2  output  5 each  regfile read addresses.
REQ-016 rf_rdata1, rf_rdata2  input  32 each  regfile read data, combinational in the same cycle.
REQ-017 stallreq_o  output  1  stall request to the pipeline controller.

Function
REQ-018 States: IDLE, WAIT, FORCE, ACK, held in a 2-bit state register; a starvation counter `cnt` is 3 bits.
REQ-019 A port is free when its id_reN is 0. Port 2 is preferred over port 1 when both are free.
REQ-020 Grant cycle definition:
- IDLE or WAIT with dbg_req=1 and a free port, or any cycle in FORCE.
- The granted port drives rf_reN=1 and rf_raddrN=dbg_addr.
- rf_rdataN is captured into dbg_data at the clock edge.
- Next state is ACK.
REQ-021 Ungranted ports pass through: rf_reN=id_reN; rf_raddrN=id_raddrN when id_reN=1, else 5'd0.
REQ-022 id_rdataN=rf_rdataN when id_reN=1 and port N is not granted; otherwise 32'h0.
REQ-023 IDLE transitions:
- dbg_req=0: stay in IDLE.
- dbg_req=1 with no free port: go to WAIT, cnt<=1.
REQ-024 WAIT transitions:
- dbg_req=0: go to IDLE, cnt<=0.
- No free port and cnt<STARVE_LIMIT: cnt<=cnt+1.
- No free port and cnt==STARVE_LIMIT: go to FORCE.
REQ-025 FORCE:
- stallreq_o=1 (combinational from state) and port 2 is granted unconditionally.
- id_rdata2=0 in that cycle; ID re-reads after the stall.
- Next state ACK, cnt<=0.
REQ-026 stallreq_o is 0 in every state other than FORCE.
REQ-027 ACK: dbg_ack=1 for exactly one cycle, dbg_req is ignored, both ports pass through, next state IDLE.
REQ-028 Latency: a grant in cycle N gives dbg_ack in cycle N+1. Minimum request-to-ack latency is 1 cycle; maximum is STARVE_LIMIT+2 cycles.
REQ-029 Throughput: at most one debug read per 2 cycles, because a request is never granted in ACK.
REQ-030 dbg_data holds its value until the next grant.
REQ-031 dbg_addr=0 is not special-cased; the regfile's zero-register behaviour applies.

Reset
REQ-032 When rst=1 at a rising edge: state<=IDLE, cnt<=0, dbg_data<=32'h0.
REQ-033 While rst=1, combinational outputs are forced: dbg_ack=0, stallreq_o=0, rf_re1=rf_re2=0, rf_raddr1=rf_raddr2=0, id_rdata1=id_rdata2=0.
REQ-034 Reset asserted in WAIT, FORCE or ACK abandons the transaction: no dbg_ack is issued afterwards and no capture occurs on the reset edge.

Verification
REQ-035 ID port 2 idle, dbg_req=1, dbg_addr=5, GPR5=32'h1234 -> rf_raddr2=5 that cycle; next cycle dbg_ack=1, dbg_data=32'h1234; id_rdata1 unaffected.
REQ-036 id_re2=1, id_re1=0, dbg_req=1, dbg_addr=7 -> port 1 granted with rf_raddr1=7; id_rdata2 equals rf_rdata2; stallreq_o stays 0.
REQ-037 Both id_re=1 continuously, STARVE_LIMIT=4, dbg_req raised at cycle 0 -> WAIT in cycles 1-4, FORCE with stallreq_o=1 in cycle 5 only, dbg_ack in cycle 6, id_rdata2=0 in cycle 5.
REQ-038 dbg_req dropped in cycle 2 of WAIT -> IDLE next cycle, cnt=0, no dbg_ack, no stall.
REQ-039 rst=1 in the FORCE cycle -> next cycle IDLE, dbg_ack=0, stallreq_o=0, dbg_data=0.
REQ-040 dbg_req held high through ACK with ports free -> grants occur in alternate cycles, never in the ACK cycle.

Source files
------------

// File: rtl/gpr_rd_arb.sv
// -----------------------------------------------------------------------------
// gpr_rd_arb
//
// Arbitrates a debug read of the general-purpose register file against the two
// ID-stage read ports. A debug read borrows whichever regfile port the ID stage
// is not using (port 2 preferred). If both ports stay busy for STARVE_LIMIT
// waiting cycles, the block raises a one-cycle pipeline stall and takes port 2
// by force. The result is registered and acknowledged one cycle after the grant.
//
// Ports
//   clk, rst                 single clock, synchronous active-high reset
//   id_re1/2, id_raddr1/2    ID-stage read requests
//   id_rdata1/2              read data returned to ID (0 when not serviced)
//   dbg_req, dbg_addr        debug read request (level, held until dbg_ack)
//   dbg_ack, dbg_data        one-cycle acknowledge with registered read data
//   rf_re1/2, rf_raddr1/2    regfile read enables/addresses
//   rf_rdata1/2              regfile read data (combinational, same cycle)
//   stallreq_o               stall request to the pipeline controller
// -----------------------------------------------------------------------------
module gpr_rd_arb #(
    parameter int unsigned STARVE_LIMIT = 4  // legal range 1..7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_re1,
    input  logic [4:0]  id_raddr1,
    input  logic        id_re2,
    input  logic [4:0]  id_raddr2,
    output logic [31:0] id_rdata1,
    output logic [31:0] id_rdata2,
    input  logic        dbg_req,
    input  logic [4:0]  dbg_addr,
    output logic        dbg_ack,
    output logic [31:0] dbg_data,
    output logic        rf_re1,
    output logic        rf_re2,
    output logic [4:0]  rf_raddr1,
    output logic [4:0]  rf_raddr2,
    input  logic [31:0] rf_rdata1,
    input  logic [31:0] rf_rdata2,
    output logic        stallreq_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FORCE = 2'd2,
        ST_ACK   = 2'd3
    } state_e;

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] dbg_data_q, dbg_data_d;

    logic can_grant;
    logic grant1;
    logic grant2;

    // A request may take a free port only from IDLE or WAIT; ACK never grants,
    // which is what limits throughput to one debug read per two cycles.
    // FORCE takes port 2 regardless of what ID is doing.
    always_comb begin
        can_grant = (state_q == ST_IDLE || state_q == ST_WAIT) && dbg_req;
        grant2    = !rst && ((can_grant && !id_re2) || state_q == ST_FORCE);
        grant1    = !rst && can_grant && id_re2 && !id_re1;
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dbg_data_d = dbg_data_q;

        if (grant2) begin
            dbg_data_d = rf_rdata2;
        end else if (grant1) begin
            dbg_data_d = rf_rdata1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (grant1 || grant2) begin
                    state_d = ST_ACK;
                    cnt_d   = 3'd0;
                end else if (dbg_req) begin
                    state_d = ST_WAIT;
                    cnt_d   = 3'd1;
                end
            end
            ST_WAIT: begin
                if (!dbg_req) begin
                    state_d = ST_IDLE;
                    cnt_d   = 3'd0;
                end else if (grant1 || grant2) begin
                    state_d = ST_ACK;
                    cnt_d   = 3'd0;
                end else if (cnt_q < LIMIT) begin
                    cnt_d = cnt_q + 3'd1;
                end else begin
                    state_d = ST_FORCE;
                end
            end
            ST_FORCE: begin
                state_d = ST_ACK;
                cnt_d   = 3'd0;
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // Reset wins over any grant, so a transaction in flight is dropped and the
    // reset edge never captures read data.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            dbg_data_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dbg_data_q <= dbg_data_d;
        end
    end

    // Regfile port muxing and ID return data. Grants already include !rst.
    always_comb begin
        rf_re1    = 1'b0;
        rf_re2    = 1'b0;
        rf_raddr1 = 5'd0;
        rf_raddr2 = 5'd0;
        id_rdata1 = 32'h0;
        id_rdata2 = 32'h0;

        if (!rst) begin
            if (grant1) begin
                rf_re1    = 1'b1;
                rf_raddr1 = dbg_addr;
            end else if (id_re1) begin
                rf_re1    = 1'b1;
                rf_raddr1 = id_raddr1;
                id_rdata1 = rf_rdata1;
            end

            if (grant2) begin
                rf_re2    = 1'b1;
                rf_raddr2 = dbg_addr;
            end else if (id_re2) begin
                rf_re2    = 1'b1;
                rf_raddr2 = id_raddr2;
                id_rdata2 = rf_rdata2;
            end
        end
    end

    assign dbg_ack    = !rst && (state_q == ST_ACK);
    assign stallreq_o = !rst && (state_q == ST_FORCE);
    assign dbg_data   = dbg_data_q;

endmodule

// File: tb/tb_gpr_rd_arb.sv
// -----------------------------------------------------------------------------
// tb_gpr_rd_arb
//
// Directed bench for gpr_rd_arb with the default STARVE_LIMIT of 4. A small
// regfile model answers reads combinationally. Stimulus pushes the expected
// debug result (data and acknowledge cycle) into a queue at the grant; a
// monitor pops and compares on every dbg_ack. Port-level outputs are checked
// directly by the stimulus on the falling edge.
// -----------------------------------------------------------------------------
module tb_gpr_rd_arb;

    typedef struct {
        logic [31:0] data;
        int          cycle;
    } ack_exp_t;

    logic        clk;
    logic        rst;
    logic        id_re1, id_re2;
    logic [4:0]  id_raddr1, id_raddr2;
    logic [31:0] id_rdata1, id_rdata2;
    logic        dbg_req;
    logic [4:0]  dbg_addr;
    logic        dbg_ack;
    logic [31:0] dbg_data;
    logic        rf_re1, rf_re2;
    logic [4:0]  rf_raddr1, rf_raddr2;
    logic [31:0] rf_rdata1, rf_rdata2;
    logic        stallreq_o;

    logic [31:0] gpr [32];
    ack_exp_t    exp_q [$];
    int          cyc;
    int          n_vec;
    int          n_fail;

    gpr_rd_arb #(.STARVE_LIMIT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .id_re1     (id_re1),
        .id_raddr1  (id_raddr1),
        .id_re2     (id_re2),
        .id_raddr2  (id_raddr2),
        .id_rdata1  (id_rdata1),
        .id_rdata2  (id_rdata2),
        .dbg_req    (dbg_req),
        .dbg_addr   (dbg_addr),
        .dbg_ack    (dbg_ack),
        .dbg_data   (dbg_data),
        .rf_re1     (rf_re1),
        .rf_re2     (rf_re2),
        .rf_raddr1  (rf_raddr1),
        .rf_raddr2  (rf_raddr2),
        .rf_rdata1  (rf_rdata1),
        .rf_rdata2  (rf_rdata2),
        .stallreq_o (stallreq_o)
    );

    // Regfile model: combinational read, register 0 reads as zero.
    assign rf_rdata1 = gpr[rf_raddr1];
    assign rf_rdata2 = gpr[rf_raddr2];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Port-level check, called on the falling edge.
    task automatic chk_ports(input string tag,
                             input logic exp_re1, input logic [4:0] exp_a1,
                             input logic exp_re2, input logic [4:0] exp_a2,
                             input logic [31:0] exp_d1, input logic [31:0] exp_d2,
                             input logic exp_stall);
        check({tag, ".rf_re1"},    32'(rf_re1),     32'(exp_re1));
        check({tag, ".rf_raddr1"}, 32'(rf_raddr1),  32'(exp_a1));
        check({tag, ".rf_re2"},    32'(rf_re2),     32'(exp_re2));
        check({tag, ".rf_raddr2"}, 32'(rf_raddr2),  32'(exp_a2));
        check({tag, ".id_rdata1"}, id_rdata1,       exp_d1);
        check({tag, ".id_rdata2"}, id_rdata2,       exp_d2);
        check({tag, ".stall"},     32'(stallreq_o), 32'(exp_stall));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_ack(input logic [31:0] data);
        ack_exp_t e;
        e.data  = data;
        e.cycle = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic set_id(input logic re1, input logic [4:0] a1,
                          input logic re2, input logic [4:0] a2);
        id_re1    = re1;
        id_raddr1 = a1;
        id_re2    = re2;
        id_raddr2 = a2;
    endtask

    // Scoreboard monitor: every acknowledge must match the oldest expectation.
    always @(negedge clk) begin
        if (dbg_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 32'(dbg_ack), 32'd0);
            end else begin
                ack_exp_t e;
                e = exp_q.pop_front();
                check("ack_data", dbg_data, e.data);
                check("ack_cycle", 32'(cyc), 32'(e.cycle));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        cyc    = 0;
        n_vec  = 0;
        n_fail = 0;
        for (int i = 0; i < 32; i++) gpr[i] = {8'hA5, 8'(i), 8'h5A, 8'(i)};
        gpr[0] = 32'h0;
        gpr[5] = 32'h0000_1234;

        // Reset with busy inputs and a pending request: outputs forced low.
        rst = 1'b1;
        set_id(1'b1, 5'd3, 1'b1, 5'd9);
        dbg_req  = 1'b1;
        dbg_addr = 5'd5;
        step();
        step();
        @(negedge clk);
        chk_ports("rst", 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
        check("rst.dbg_ack", 32'(dbg_ack), 32'd0);
        check("rst.dbg_data", dbg_data, 32'h0);
        step();

        // Port 2 free: debug read of GPR5 via port 2, ID port 1 unaffected.
        rst = 1'b0;
        set_id(1'b1, 5'd3, 1'b0, 5'd0);
        dbg_req  = 1'b1;
        dbg_addr = 5'd5;
        expect_ack(32'h0000_1234);
        @(negedge clk);
        chk_ports("p2grant", 1'b1, 5'd3, 1'b1, 5'd5, 32'hA503_5A03, 32'h0, 1'b0);
        step();
        @(negedge clk);
        chk_ports("p2ack", 1'b1, 5'd3, 1'b0, 5'd0, 32'hA503_5A03, 32'h0, 1'b0);
        step();
        dbg_req = 1'b0;
        @(negedge clk);
        check("hold.dbg_data", dbg_data, 32'h0000_1234);
        check("hold.dbg_ack", 32'(dbg_ack), 32'd0);
        step();

        // Port 2 busy, port 1 free: port 1 granted.
        set_id(1'b0, 5'd0, 1'b1, 5'd9);
        dbg_req  = 1'b1;
        dbg_addr = 5'd7;
        expect_ack(32'hA507_5A07);
        @(negedge clk);
        chk_ports("p1grant", 1'b1, 5'd7, 1'b1, 5'd9, 32'h0, 32'hA509_5A09, 1'b0);
        step();
        @(negedge clk);
        chk_ports("p1ack", 1'b0, 5'd0, 1'b1, 5'd9, 32'h0, 32'hA509_5A09, 1'b0);
        step();
        dbg_req = 1'b0;
        step();

        // Both busy, request dropped in the second WAIT cycle: no ack, no stall.
        set_id(1'b1, 5'd1, 1'b1, 5'd2);
        dbg_req  = 1'b1;
        dbg_addr = 5'd12;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) dbg_req = 1'b0;
            @(negedge clk);
            chk_ports("drop", 1'b1, 5'd1, 1'b1, 5'd2, 32'hA501_5A01, 32'hA502_5A02, 1'b0);
            step();
        end

        // Both busy continuously: WAIT cycles 1-4, FORCE cycle 5, ack cycle 6.
        dbg_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk_ports("starve", 1'b1, 5'd1, 1'b1, 5'd2, 32'hA501_5A01, 32'hA502_5A02, 1'b0);
            step();
        end
        expect_ack(32'hA50C_5A0C);
        @(negedge clk);
        chk_ports("force", 1'b1, 5'd1, 1'b1, 5'd12, 32'hA501_5A01, 32'h0, 1'b1);
        step();
        @(negedge clk);
        chk_ports("force_ack", 1'b1, 5'd1, 1'b1, 5'd2, 32'hA501_5A01, 32'hA502_5A02, 1'b0);
        step();
        dbg_req = 1'b0;
        step();

        // Reset asserted in the FORCE cycle abandons the read.
        dbg_req = 1'b1;
        for (int k = 0; k < 5; k++) step();
        rst = 1'b1;
        @(negedge clk);
        chk_ports("rst_force", 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
        step();
        rst     = 1'b0;
        dbg_req = 1'b0;
        @(negedge clk);
        check("post_rst.dbg_ack", 32'(dbg_ack), 32'd0);
        check("post_rst.stall", 32'(stallreq_o), 32'd0);
        check("post_rst.dbg_data", dbg_data, 32'h0);
        step();
        @(negedge clk);
        check("post_rst2.stall", 32'(stallreq_o), 32'd0);
        step();

        // Request held through ACK with free ports: grants on alternate cycles.
        set_id(1'b0, 5'd0, 1'b0, 5'd0);
        dbg_req  = 1'b1;
        dbg_addr = 5'd20;
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) begin
                expect_ack(32'hA514_5A14);
                @(negedge clk);
                chk_ports("alt_grant", 1'b0, 5'd0, 1'b1, 5'd20, 32'h0, 32'h0, 1'b0);
            end else begin
                @(negedge clk);
                chk_ports("alt_ack", 1'b0, 5'd0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
            end
            step();
        end
        dbg_req = 1'b0;
        step();

        // Address 0 is read through like any other register.
        set_id(1'b1, 5'd4, 1'b0, 5'd0);
        dbg_req  = 1'b1;
        dbg_addr = 5'd0;
        expect_ack(32'h0);
        @(negedge clk);
        chk_ports("zero", 1'b1, 5'd4, 1'b1, 5'd0, 32'hA504_5A04, 32'h0, 1'b0);
        step();
        step();
        dbg_req = 1'b0;
        step();
        step();

        check("pending_acks", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
